if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Sequences instruction fetches between the PREIF stage and the instruction-side cache bus (cpu_ibus, SRAM-like request/addr_ok/data_ok protocol).
- Issues one request per PREIF PC and holds returned instructions while IF is stalled.
- Discards responses belonging to flushed fetches.
- Drives a stall request to the hazard unit while a fetch is outstanding, and the instruction, PC and exception flag consumed by the IF/ID register.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width
- NOP_INSTR, 32'h0000_0000, instruction word emitted for discarded, exception or empty slots

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- IF_Wr  in  1  pipeline advance enable for IF; 0 = IF held
- IF_Flush  in  1  flush IF; squash current and in-flight fetch
- preif_pc  in  ADDR_W  next fetch PC from PREIF
- preif_valid  in  1  preif_pc is valid
- preif_ready  out  1  controller accepts preif_pc this cycle
- ibus_req  out  1  request to instruction cache
- ibus_addr  out  ADDR_W  request address
- ibus_addr_ok  in  1  cache accepted address
- ibus_data_ok  in  1  read data valid
- ibus_rdata  in  DATA_W  read data
- if_pc  out  ADDR_W  PC of instruction presented to ID
- if_instr  out  DATA_W  instruction presented to ID
- if_instr_valid  out  1  if_instr/if_pc valid
- if_adel  out  1  fetch address error (pc[1:0] != 0)
- if_stall_req  out  1  IF cannot complete this cycle

Behaviour:
- Reset (async, resetn=0), effective immediately:
  - state=IDLE, discard=0
  - ibus_req=0, ibus_addr=0
  - if_pc=0, if_instr=NOP_INSTR, if_instr_valid=0, if_adel=0
  - preif_ready=1, if_stall_req=0
- Outstanding requests: at most one.
- IDLE:
  - preif_ready=1.
  - Accept happens on preif_valid & IF_Wr & !IF_Flush; pc is latched into cur_pc.
  - Accepted pc with pc[1:0]!=0: no bus request. Next cycle output if_pc=pc, if_instr=NOP_INSTR, if_adel=1, if_instr_valid=1. Stay IDLE.
  - Otherwise go to REQ.
- REQ:
  - ibus_req=1, ibus_addr=cur_pc, if_stall_req=1, preif_ready=0.
  - ibus_addr_ok -> WAIT.
  - ibus_req is never deasserted before addr_ok, including on flush.
  - IF_Flush in REQ sets discard=1.
- WAIT:
  - ibus_req=0, if_stall_req=1.
  - On ibus_data_ok:
    - discard=1: drop data, clear discard, go to IDLE, if_instr_valid=0.
    - discard=0 and IF_Wr=1: present the data next cycle (if_instr=rdata, if_pc=cur_pc, valid=1, adel=0), go to IDLE.
    - discard=0 and IF_Wr=0: latch rdata into the hold buffer, go to HOLD.
  - IF_Flush in WAIT sets discard=1, including in the same cycle as data_ok; that data is dropped.
  - If data_ok and addr_ok-of-REQ coincide in consecutive cycles, normal handling applies. data_ok never precedes addr_ok.
- HOLD:
  - Outputs = buffered instruction, valid=1, if_stall_req=0, preif_ready=0.
  - On IF_Wr=1 the buffer is consumed. The next PREIF PC may be accepted in the same cycle (ready=1 combinationally), going to REQ.
  - IF_Flush in HOLD clears the buffer, valid=0, go to IDLE, no bus activity.
- IF_Flush in IDLE: no accept that cycle; if_instr_valid=0 next cycle.
- Outputs hold their values whenever IF_Wr=0, except on flush.
- Latency: accept -> req same+1 cycle; data_ok -> if_instr_valid next edge. Minimum 3 cycles per fetch with a 1-cycle-addr_ok/1-cycle-data_ok cache.

Test Plan:
- Single fetch:
  - Stimulus: reset, preif_pc=32'hBFC0_0000 valid, cache addr_ok 1 cycle after req, data_ok next cycle with rdata=32'h2408_0001.
  - Required: ibus_addr=BFC00000, if_instr=24080001, if_pc=BFC00000, valid=1. if_stall_req high exactly during REQ and WAIT.
- Misaligned PC:
  - Stimulus: preif_pc=32'hBFC0_0002.
  - Required: ibus_req never asserted; next cycle if_adel=1, if_instr=0, valid=1.
- Flush in WAIT:
  - Stimulus: fetch 32'hBFC0_0004; IF_Flush pulses the cycle after addr_ok; data_ok returns 32'hDEAD_BEEF.
  - Required: data dropped, if_instr_valid=0. A following fetch of 32'h8000_0180 returns its own data correctly.
- Flush in REQ with slow addr_ok:
  - Stimulus: addr_ok delayed 4 cycles, IF_Flush in cycle 2.
  - Required: ibus_req stays 1 until addr_ok; response discarded.
- Stall hold:
  - Stimulus: IF_Wr=0 when data_ok delivers 32'h1234_5678; IF_Wr released 3 cycles later.
  - Required: if_instr stays 12345678 with valid=1 throughout; preif_ready=0 until release, then the next PC is accepted that cycle.
- Async reset:
  - Stimulus: resetn driven low mid-WAIT, off-clock-edge.
  - Required: all outputs take reset values immediately. A late data_ok after reset deassertion is ignored (state IDLE).

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-side cache bus (cpu_ibus) shared by the fetch controller and the
// I-cache: SRAM-like request / addr_ok / data_ok handshake.
interface if_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              ibus_req;
  logic [ADDR_W-1:0] ibus_addr;
  logic              ibus_addr_ok;
  logic              ibus_data_ok;
  logic [DATA_W-1:0] ibus_rdata;

  modport master (
    output ibus_req,
    output ibus_addr,
    input  ibus_addr_ok,
    input  ibus_data_ok,
    input  ibus_rdata
  );

  modport slave (
    input  ibus_req,
    input  ibus_addr,
    output ibus_addr_ok,
    output ibus_data_ok,
    output ibus_rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer between PREIF and the I-cache: one outstanding request,
// stall-hold of returned instructions, and squashing of flushed responses.
module if_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              IF_Wr,
  input  logic              IF_Flush,
  input  logic [ADDR_W-1:0] preif_pc,
  input  logic              preif_valid,
  output logic              preif_ready,
  if_fetch_ctrl_if.master   ibus,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_instr_valid,
  output logic              if_adel,
  output logic              if_stall_req
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic              discard_q;
  logic [ADDR_W-1:0] cur_pc_q;
  logic              ibus_req_q;
  logic              stall_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [DATA_W-1:0] if_instr_q;
  logic              if_valid_q;
  logic              if_adel_q;

  logic accept;
  logic misaligned;
  logic data_arrived;
  logic keep_data;

  // A held instruction frees the slot only in the cycle ID actually takes it.
  assign preif_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && IF_Wr);
  assign accept       = preif_ready && preif_valid && IF_Wr && !IF_Flush;
  assign misaligned   = (preif_pc[1:0] != 2'b00);
  assign data_arrived = (state_q == S_WAIT) && ibus.ibus_data_ok;
  assign keep_data    = data_arrived && !discard_q && !IF_Flush;

  assign ibus.ibus_req  = ibus_req_q;
  assign ibus.ibus_addr = cur_pc_q;

  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign if_instr_valid = if_valid_q;
  assign if_adel        = if_adel_q;
  assign if_stall_req   = stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      discard_q  <= 1'b0;
      cur_pc_q   <= '0;
      ibus_req_q <= 1'b0;
      stall_q    <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      if_adel_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (IF_Flush) begin
            state_q <= S_IDLE;
          end else if (accept) begin
            cur_pc_q <= preif_pc;
            if (misaligned) begin
              state_q <= S_IDLE;
            end else begin
              state_q    <= S_REQ;
              ibus_req_q <= 1'b1;
              stall_q    <= 1'b1;
            end
          end else if ((state_q == S_HOLD) && IF_Wr) begin
            state_q <= S_IDLE;
          end
        end

        // The request must stay up until the cache takes it, flush or not;
        // a flush only marks the eventual response as unwanted.
        S_REQ: begin
          if (IF_Flush) begin
            discard_q <= 1'b1;
          end
          if (ibus.ibus_addr_ok) begin
            ibus_req_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (ibus.ibus_data_ok) begin
            discard_q <= 1'b0;
            stall_q   <= 1'b0;
            state_q   <= (keep_data && !IF_Wr) ? S_HOLD : S_IDLE;
          end else if (IF_Flush) begin
            discard_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // The IF/ID-facing registers double as the hold buffer while in S_HOLD.
      if (IF_Flush) begin
        if_instr_q <= NOP_INSTR;
        if_valid_q <= 1'b0;
        if_adel_q  <= 1'b0;
      end else if (keep_data) begin
        if_pc_q    <= cur_pc_q;
        if_instr_q <= ibus.ibus_rdata;
        if_valid_q <= 1'b1;
        if_adel_q  <= 1'b0;
      end else if (IF_Wr) begin
        if (accept && misaligned) begin
          if_pc_q    <= preif_pc;
          if_instr_q <= NOP_INSTR;
          if_valid_q <= 1'b1;
          if_adel_q  <= 1'b1;
        end else begin
          if_instr_q <= NOP_INSTR;
          if_valid_q <= 1'b0;
          if_adel_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed fetch scenarios followed by randomized
// traffic, all checked against a transaction-level model of the fetch slot.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ifWr;
  logic        ifFlush;
  logic        preifValid;
  logic [31:0] preifPc;
  logic        preifReady;
  logic [31:0] ifPc;
  logic [31:0] ifInstr;
  logic        ifInstrValid;
  logic        ifAdel;
  logic        ifStallReq;

  int tests = 0;
  int fails = 0;

  if_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ibus ();

  if_fetch_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .IF_Wr(ifWr),
    .IF_Flush(ifFlush),
    .preif_pc(preifPc),
    .preif_valid(preifValid),
    .preif_ready(preifReady),
    .ibus(ibus),
    .if_pc(ifPc),
    .if_instr(ifInstr),
    .if_instr_valid(ifInstrValid),
    .if_adel(ifAdel),
    .if_stall_req(ifStallReq)
  );

  always #5 clk = ~clk;

  // Reference model: one fetch slot (pending request and whether the cache
  // has taken its address), a holding flag, and the instruction ID sees.
  bit          mPending;
  bit          mAddrAcc;
  bit          mSquash;
  bit          mHolding;
  logic [31:0] mFetchPc;
  bit          mOutValid;
  logic [31:0] mOutPc;
  logic [31:0] mOutInstr;
  bit          mOutAdel;

  task automatic modelReset();
    mPending  = 1'b0;
    mAddrAcc  = 1'b0;
    mSquash   = 1'b0;
    mHolding  = 1'b0;
    mFetchPc  = 32'h0;
    mOutValid = 1'b0;
    mOutPc    = 32'h0;
    mOutInstr = NOP;
    mOutAdel  = 1'b0;
  endtask

  function automatic bit modelReady();
    return !mPending && (!mHolding || ifWr);
  endfunction

  task automatic modelEdge();
    bit acc;
    bit got;
    got = 1'b0;
    acc = modelReady() && preifValid && ifWr && !ifFlush;
    if (mPending) begin
      if (!mAddrAcc) begin
        if (ifFlush) mSquash = 1'b1;
        if (ibus.ibus_addr_ok) mAddrAcc = 1'b1;
      end else if (ibus.ibus_data_ok) begin
        got      = !(mSquash || ifFlush);
        mPending = 1'b0;
        mSquash  = 1'b0;
        mHolding = got && !ifWr;
      end else if (ifFlush) begin
        mSquash = 1'b1;
      end
    end else if (ifFlush) begin
      mHolding = 1'b0;
    end else if (acc) begin
      mHolding = 1'b0;
      if (preifPc[1:0] == 2'b00) begin
        mPending = 1'b1;
        mAddrAcc = 1'b0;
        mFetchPc = preifPc;
      end
    end else if (ifWr) begin
      mHolding = 1'b0;
    end

    if (ifFlush) begin
      mOutValid = 1'b0;
    end else if (got) begin
      mOutValid = 1'b1;
      mOutPc    = mFetchPc;
      mOutInstr = ibus.ibus_rdata;
      mOutAdel  = 1'b0;
    end else if (ifWr) begin
      if (acc && (preifPc[1:0] != 2'b00)) begin
        mOutValid = 1'b1;
        mOutPc    = preifPc;
        mOutInstr = NOP;
        mOutAdel  = 1'b1;
      end else begin
        mOutValid = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compareAll();
    checkOutput("preif_ready", 32'(preifReady), 32'(modelReady()));
    checkOutput("ibus_req", 32'(ibus.ibus_req), 32'(mPending && !mAddrAcc));
    if (mPending && !mAddrAcc) checkOutput("ibus_addr", ibus.ibus_addr, mFetchPc);
    checkOutput("if_stall_req", 32'(ifStallReq), 32'(mPending));
    checkOutput("if_instr_valid", 32'(ifInstrValid), 32'(mOutValid));
    if (mOutValid) begin
      checkOutput("if_pc", ifPc, mOutPc);
      checkOutput("if_instr", ifInstr, mOutInstr);
      checkOutput("if_adel", 32'(ifAdel), 32'(mOutAdel));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req"}, 32'(ibus.ibus_req), 32'h0);
    checkOutput({tag, "_addr"}, ibus.ibus_addr, 32'h0);
    checkOutput({tag, "_pc"}, ifPc, 32'h0);
    checkOutput({tag, "_instr"}, ifInstr, NOP);
    checkOutput({tag, "_valid"}, 32'(ifInstrValid), 32'h0);
    checkOutput({tag, "_adel"}, 32'(ifAdel), 32'h0);
    checkOutput({tag, "_ready"}, 32'(preifReady), 32'h1);
    checkOutput({tag, "_stall"}, 32'(ifStallReq), 32'h0);
  endtask

  // Inputs are already set at a falling edge; check, advance the model across
  // the rising edge, and return on the next falling edge.
  task automatic stepCycle();
    #1;
    compareAll();
    modelEdge();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit wr, input bit flush, input bit pv, input logic [31:0] pc,
                               input bit aok, input bit dok, input logic [31:0] rd);
    ifWr              = wr;
    ifFlush           = flush;
    preifValid        = pv;
    preifPc           = pc;
    ibus.ibus_addr_ok = aok;
    ibus.ibus_data_ok = dok;
    ibus.ibus_rdata   = rd;
    stepCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn            = 1'b0;
    ifWr              = 1'b0;
    ifFlush           = 1'b0;
    preifValid        = 1'b0;
    preifPc           = 32'h0;
    ibus.ibus_addr_ok = 1'b0;
    ibus.ibus_data_ok = 1'b0;
    ibus.ibus_rdata   = 32'h0;
    modelReset();
    #3;
    checkResetValues("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Single fetch with a 1-cycle addr_ok / 1-cycle data_ok cache.
    applyStimulus(1, 0, 1, 32'hBFC0_0000, 0, 0, 32'h0);
    checkOutput("single_req", 32'(ibus.ibus_req), 32'h1);
    checkOutput("single_addr", ibus.ibus_addr, 32'hBFC0_0000);
    checkOutput("single_stall_req", 32'(ifStallReq), 32'h1);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("single_req_drop", 32'(ibus.ibus_req), 32'h0);
    checkOutput("single_stall_wait", 32'(ifStallReq), 32'h1);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h2408_0001);
    checkOutput("single_valid", 32'(ifInstrValid), 32'h1);
    checkOutput("single_instr", ifInstr, 32'h2408_0001);
    checkOutput("single_pc", ifPc, 32'hBFC0_0000);
    checkOutput("single_stall_done", 32'(ifStallReq), 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);

    // Misaligned PC: no bus request, address error presented next cycle.
    applyStimulus(1, 0, 1, 32'hBFC0_0002, 0, 0, 32'h0);
    checkOutput("misal_adel", 32'(ifAdel), 32'h1);
    checkOutput("misal_instr", ifInstr, NOP);
    checkOutput("misal_valid", 32'(ifInstrValid), 32'h1);
    checkOutput("misal_pc", ifPc, 32'hBFC0_0002);
    checkOutput("misal_req", 32'(ibus.ibus_req), 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("misal_req_after", 32'(ibus.ibus_req), 32'h0);

    // Flush while waiting for data; the returned word must be dropped.
    applyStimulus(1, 0, 1, 32'hBFC0_0004, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("flwait_valid", 32'(ifInstrValid), 32'h0);
    checkOutput("flwait_stall", 32'(ifStallReq), 32'h0);
    applyStimulus(1, 0, 1, 32'h8000_0180, 0, 0, 32'h0);
    checkOutput("flwait_next_addr", ibus.ibus_addr, 32'h8000_0180);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h3C1A_BFC0);
    checkOutput("flwait_next_instr", ifInstr, 32'h3C1A_BFC0);
    checkOutput("flwait_next_pc", ifPc, 32'h8000_0180);
    checkOutput("flwait_next_valid", 32'(ifInstrValid), 32'h1);

    // Flush during a slow request: ibus_req must persist until addr_ok.
    applyStimulus(1, 0, 1, 32'hBFC0_0008, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("flreq_req_c2", 32'(ibus.ibus_req), 32'h1);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("flreq_req_c3", 32'(ibus.ibus_req), 32'h1);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("flreq_req_c4", 32'(ibus.ibus_req), 32'h1);
    checkOutput("flreq_addr_c4", ibus.ibus_addr, 32'hBFC0_0008);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("flreq_req_done", 32'(ibus.ibus_req), 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h1111_1111);
    checkOutput("flreq_valid", 32'(ifInstrValid), 32'h0);

    // IF held when data returns: instruction kept until IF_Wr is released.
    applyStimulus(1, 0, 1, 32'hBFC0_000C, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 1, 32'hBFC0_0010, 0, 1, 32'h1234_5678);
    for (int k = 0; k < 3; k++) begin
      checkOutput("hold_instr", ifInstr, 32'h1234_5678);
      checkOutput("hold_valid", 32'(ifInstrValid), 32'h1);
      checkOutput("hold_ready", 32'(preifReady), 32'h0);
      checkOutput("hold_stall", 32'(ifStallReq), 32'h0);
      if (k < 2) applyStimulus(0, 0, 1, 32'hBFC0_0010, 0, 0, 32'h0);
    end
    applyStimulus(1, 0, 1, 32'hBFC0_0010, 0, 0, 32'h0);
    checkOutput("hold_next_req", 32'(ibus.ibus_req), 32'h1);
    checkOutput("hold_next_addr", ibus.ibus_addr, 32'hBFC0_0010);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'hAABB_CCDD);
    checkOutput("hold_next_instr", ifInstr, 32'hAABB_CCDD);
    checkOutput("hold_next_pc", ifPc, 32'hBFC0_0010);

    // Asynchronous reset in the middle of a wait, away from any clock edge.
    applyStimulus(1, 0, 1, 32'hBFC0_0014, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    ifWr              = 1'b0;
    ibus.ibus_addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checkResetValues("async");
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    checkOutput("late_data_valid", 32'(ifInstrValid), 32'h0);
    checkOutput("late_data_stall", 32'(ifStallReq), 32'h0);
    checkOutput("late_data_ready", 32'(preifReady), 32'h1);

    // Randomized traffic against the model, with a legal cache responder.
    for (int i = 0; i < 400; i++) begin
      bit          wr;
      bit          fl;
      bit          pv;
      bit          aok;
      bit          dok;
      logic [31:0] pc;
      wr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 11) == 0);
      pv = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      if ($urandom_range(0, 5) != 0) pc[1:0] = 2'b00;
      aok = mPending && !mAddrAcc && ($urandom_range(0, 1) == 1);
      dok = mPending && mAddrAcc && ($urandom_range(0, 1) == 1);
      applyStimulus(wr, fl, pv, pc, aok, dok, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
